fpga_cfg_loader: RTL and testbench

Serial configuration loader for the FPGA fabric tile. It accepts a configuration bitstream one bit per accepted cycle over a valid/ready handshake and assembles the bits into frames. Each completed frame is presented with a one-cycle write strobe that drives the clock-enable of the tile's enable-gated configuration flip-flops. It sits directly upstream of the DFF configuration storage and is the only writer of it.

---
 rtl/fpga_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// Serial configuration loader: shifts a bitstream into FRAME_W-bit frames and
// strobes each frame into the tile's DFF storage. Optional parity via FPGA_CFG_PARITY_EN.
module fpga_cfg_loader #(
  parameter int FRAME_W  = 16,
  parameter int N_FRAMES = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 bit_valid_i,
  input  logic                 bit_i,
  output logic                 bit_ready_o,
  output logic                 busy_o,
  output logic [FRAME_W-1:0]   frame_o,
  output logic [((N_FRAMES > 1) ? $clog2(N_FRAMES) : 1)-1:0] frame_addr_o,
  output logic                 frame_we_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int AW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int BW = $clog2(FRAME_W);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_W - 1);
  localparam logic [AW-1:0] LAST_FRAME = AW'(N_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
`ifdef FPGA_CFG_PARITY_EN
    PAR,
`endif
    WRITE,
    DONE,
    ERR
  } state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sreg_q, sreg_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic [AW-1:0]        frameCnt_q, frameCnt_d;
  logic [FRAME_W-1:0]   lastFrame_q, lastFrame_d;
  logic [AW-1:0]        lastAddr_q, lastAddr_d;
  logic                 bitReady;
  logic                 writeStrobe;
  logic                 donePulse;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bitCnt_q    <= '0;
      frameCnt_q  <= '0;
      lastFrame_q <= '0;
      lastAddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bitCnt_q    <= bitCnt_d;
      frameCnt_q  <= frameCnt_d;
      lastFrame_q <= lastFrame_d;
      lastAddr_q  <= lastAddr_d;
    end
  end

  // Counters saturate at their terminal values; only start clears the frame counter.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bitCnt_d    = bitCnt_q;
    frameCnt_d  = frameCnt_q;
    lastFrame_d = lastFrame_q;
    lastAddr_d  = lastAddr_q;
    bitReady    = 1'b0;
    writeStrobe = 1'b0;
    donePulse   = 1'b0;

    case (state_q)
      IDLE, ERR: begin
        if (start_i) begin
          state_d    = SHIFT;
          bitCnt_d   = '0;
          frameCnt_d = '0;
        end
      end
      SHIFT: begin
        bitReady = 1'b1;
        if (bit_valid_i) begin
          sreg_d = {sreg_q[FRAME_W-2:0], bit_i};
          if (bitCnt_q == LAST_BIT) begin
`ifdef FPGA_CFG_PARITY_EN
            state_d = PAR;
`else
            state_d = WRITE;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
`ifdef FPGA_CFG_PARITY_EN
      PAR: begin
        bitReady = 1'b1;
        if (bit_valid_i) begin
          if ((^{sreg_q, bit_i}) == 1'b0) state_d = WRITE;
          else                            state_d = ERR;
        end
      end
`endif
      WRITE: begin
        writeStrobe = 1'b1;
        lastFrame_d = sreg_q;
        lastAddr_d  = frameCnt_q;
        if (frameCnt_q == LAST_FRAME) begin
          state_d = DONE;
        end else begin
          frameCnt_d = frameCnt_q + 1'b1;
          bitCnt_d   = '0;
          state_d    = SHIFT;
        end
      end
      DONE: begin
        donePulse = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bit_ready_o  = bitReady;
  assign frame_we_o   = writeStrobe;
  assign done_o       = donePulse;
  assign busy_o       = (state_q != IDLE) && (state_q != ERR);
  assign frame_o      = writeStrobe ? sreg_q : lastFrame_q;
  assign frame_addr_o = writeStrobe ? frameCnt_q : lastAddr_q;

`ifdef FPGA_CFG_PARITY_EN
  assign err_o = (state_q == ERR);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with FRAME_W=4, N_FRAMES=2.
// Parity-specific steps are compiled only when FPGA_CFG_PARITY_EN is defined.
module tb_fpga_cfg_loader;

  localparam int FW = 4;
  localparam int NF = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          bit_valid_i;
  logic          bit_i;
  logic          bit_ready_o;
  logic          busy_o;
  logic [FW-1:0] frame_o;
  logic [0:0]    frame_addr_o;
  logic          frame_we_o;
  logic          done_o;
  logic          err_o;

  int   errors  = 0;
  int   checks  = 0;
  int   weCount = 0;
  logic errSeen = 1'b0;

  fpga_cfg_loader #(.FRAME_W(FW), .N_FRAMES(NF)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .bit_valid_i  (bit_valid_i),
    .bit_i        (bit_i),
    .bit_ready_o  (bit_ready_o),
    .busy_o       (busy_o),
    .frame_o      (frame_o),
    .frame_addr_o (frame_addr_o),
    .frame_we_o   (frame_we_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Mid-cycle record of write strobes and any err_o activity.
  always @(negedge clk_i) begin
    if (frame_we_o) weCount++;
    if (err_o) errSeen = 1'b1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic b);
    start_i     = s;
    bit_valid_i = v;
    bit_i       = b;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends one frame MSB first; optional 3-cycle stall before bit stallAt,
  // optional start_i pulse alongside bit startAt. Ends with the DUT in WRITE.
  task automatic sendFrame(input logic [3:0] v, input int stallAt, input int startAt);
    for (int i = 0; i < FW; i++) begin
      if (i == stallAt) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b0, 1'b0, 1'b1);
          checkOutput("stall_ready", {31'd0, bit_ready_o}, 32'd1);
          checkOutput("stall_we", {31'd0, frame_we_o}, 32'd0);
        end
      end
      applyStimulus(i == startAt, 1'b1, v[3-i]);
    end
`ifdef FPGA_CFG_PARITY_EN
    applyStimulus(1'b0, 1'b1, ^v);
`endif
    start_i     = 1'b0;
    bit_valid_i = 1'b0;
  endtask

  initial begin
    reset_i     = 1'b1;
    start_i     = 1'b0;
    bit_valid_i = 1'b0;
    bit_i       = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, bit_ready_o}, 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    checkOutput("rst_ready2", {31'd0, bit_ready_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_we", {31'd0, frame_we_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_frame", {28'd0, frame_o}, 32'd0);
    checkOutput("rst_addr", {31'd0, frame_addr_o}, 32'd0);

    // Basic two-frame load, no stalls.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s1_ready", {31'd0, bit_ready_o}, 32'd1);
    checkOutput("s1_busy", {31'd0, busy_o}, 32'd1);
    sendFrame(4'b1011, -1, -1);
    checkOutput("s1_we0", {31'd0, frame_we_o}, 32'd1);
    checkOutput("s1_frame0", {28'd0, frame_o}, 32'hB);
    checkOutput("s1_addr0", {31'd0, frame_addr_o}, 32'd0);
    checkOutput("s1_wready", {31'd0, bit_ready_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s1_we_off", {31'd0, frame_we_o}, 32'd0);
    checkOutput("s1_hold_frame", {28'd0, frame_o}, 32'hB);
    checkOutput("s1_ready2", {31'd0, bit_ready_o}, 32'd1);
    sendFrame(4'b0110, -1, -1);
    checkOutput("s1_we1", {31'd0, frame_we_o}, 32'd1);
    checkOutput("s1_frame1", {28'd0, frame_o}, 32'h6);
    checkOutput("s1_addr1", {31'd0, frame_addr_o}, 32'd1);
    checkOutput("s1_done_early", {31'd0, done_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s1_done", {31'd0, done_o}, 32'd1);
    checkOutput("s1_done_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("s1_done_we", {31'd0, frame_we_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s1_idle_done", {31'd0, done_o}, 32'd0);
    checkOutput("s1_idle_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("s1_idle_frame", {28'd0, frame_o}, 32'h6);
    checkOutput("s1_idle_addr", {31'd0, frame_addr_o}, 32'd1);
    checkOutput("s1_wecount", weCount, 32'd2);

    // Stall mid-frame, and a start pulse during SHIFT that must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendFrame(4'b1011, 2, -1);
    checkOutput("s2_we0", {31'd0, frame_we_o}, 32'd1);
    checkOutput("s2_frame0", {28'd0, frame_o}, 32'hB);
    checkOutput("s2_addr0", {31'd0, frame_addr_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendFrame(4'b0110, -1, 2);
    checkOutput("s3_we1", {31'd0, frame_we_o}, 32'd1);
    checkOutput("s3_frame1", {28'd0, frame_o}, 32'h6);
    checkOutput("s3_addr1", {31'd0, frame_addr_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s3_done", {31'd0, done_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s3_wecount", weCount, 32'd4);

    // Reset asserted after two bits of frame 1.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendFrame(4'b1011, -1, -1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    bit_valid_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    checkOutput("s4_ready", {31'd0, bit_ready_o}, 32'd0);
    checkOutput("s4_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("s4_we", {31'd0, frame_we_o}, 32'd0);
    checkOutput("s4_frame", {28'd0, frame_o}, 32'd0);
    checkOutput("s4_addr", {31'd0, frame_addr_o}, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    checkOutput("s4_wecount", weCount, 32'd5);
    checkOutput("s4_idle_ready", {31'd0, bit_ready_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendFrame(4'b0110, -1, -1);
    checkOutput("s4_addr0", {31'd0, frame_addr_o}, 32'd0);
    checkOutput("s4_frame0", {28'd0, frame_o}, 32'h6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendFrame(4'b1001, -1, -1);
    checkOutput("s4_addr1", {31'd0, frame_addr_o}, 32'd1);
    checkOutput("s4_frame1", {28'd0, frame_o}, 32'h9);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s4_done", {31'd0, done_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef FPGA_CFG_PARITY_EN
    // Good parity writes; bad parity goes to sticky error until restart.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendFrame(4'b1011, -1, -1);
    checkOutput("p_we_good", {31'd0, frame_we_o}, 32'd1);
    checkOutput("p_frame_good", {28'd0, frame_o}, 32'hB);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FW; i++) applyStimulus(1'b0, 1'b1, (i != 1));
    applyStimulus(1'b0, 1'b1, 1'b0);
    bit_valid_i = 1'b0;
    checkOutput("p_err", {31'd0, err_o}, 32'd1);
    checkOutput("p_we_bad", {31'd0, frame_we_o}, 32'd0);
    checkOutput("p_err_ready", {31'd0, bit_ready_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("p_err_hold", {31'd0, err_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("p_err_clr", {31'd0, err_o}, 32'd0);
    checkOutput("p_busy", {31'd0, busy_o}, 32'd1);
    start_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
`else
    checkOutput("err_never", {31'd0, errSeen}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
